// File: rtl/pipe_pkg.sv
// Shared pipeline constants for the hazard/forwarding scoreboard.
// Default geometry and stage indices for the EXE/MEM/WB pipeline.
package pipe_pkg;

   localparam int NSTAGE_DEF = 3;
   localparam int AW_DEF     = 5;
   localparam int DW_DEF     = 32;

   localparam int ST_EXE = 0;
   localparam int ST_MEM = 1;
   localparam int ST_WB  = 2;

   typedef logic [AW_DEF-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/sb_port_sel.sv
// Per-read-port producer select: youngest matching in-flight stage wins.
// SCOREBOARD_FWD_EN selects full forwarding; otherwise interlock-only.
module sb_port_sel
   import pipe_pkg::*;
#(
   parameter int NSTAGE = NSTAGE_DEF,
   parameter int AW     = AW_DEF,
   parameter int DW     = DW_DEF
)(
   input  logic [NSTAGE-1:0]    tv,
   input  logic [NSTAGE*AW-1:0] ta,
   input  logic [AW-1:0]        raddr,
   input  logic [NSTAGE-1:0]    st_data_ok,
   input  logic [NSTAGE*DW-1:0] st_wdata,
   input  logic [DW-1:0]        rf_rdata,
   output logic                 hazard,
   output logic [DW-1:0]        rdata
);

   logic          hit_s;
   logic          ok_s;
   logic [DW-1:0] data_s;

   // Priority scan from oldest to youngest so the lowest stage index overrides.
   always_comb begin
      hit_s  = 1'b0;
      ok_s   = 1'b0;
      data_s = rf_rdata;
      for (int i = NSTAGE - 1; i >= 0; i--) begin
         if (tv[i] && (ta[i*AW +: AW] == raddr) && (raddr != {AW{1'b0}})) begin
            hit_s  = 1'b1;
            ok_s   = st_data_ok[i];
            data_s = st_wdata[i*DW +: DW];
         end else begin
            hit_s  = hit_s;
         end
      end
   end

`ifdef SCOREBOARD_FWD_EN
   assign hazard = hit_s & ~ok_s;
   assign rdata  = data_s;
`else
   // Interlock-only: producer data never reaches the operand path.
   logic unused_fwd_s;
   assign unused_fwd_s = ok_s ^ (^data_s);
   assign hazard       = hit_s;
   assign rdata        = rf_rdata;
`endif

endmodule

// File: rtl/fwd_scoreboard.sv
// Hazard/forwarding scoreboard: per-stage destination tags, stall and stall counter.
// Build option SCOREBOARD_FWD_EN enables forwarding (else interlock-only).
module fwd_scoreboard
   import pipe_pkg::*;
#(
   parameter int NSTAGE = NSTAGE_DEF,
   parameter int NREAD  = 2,
   parameter int DW     = DW_DEF,
   parameter int AW     = AW_DEF
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 id_valid,
   input  logic                 id_rf_we,
   input  logic [AW-1:0]        id_rf_waddr,
   input  logic [NREAD*AW-1:0]  id_raddr,
   input  logic [NSTAGE-1:0]    st_ld,
   input  logic [NSTAGE-1:0]    st_leave,
   input  logic [NSTAGE-1:0]    flush,
   input  logic [NSTAGE-1:0]    st_data_ok,
   input  logic [NSTAGE*DW-1:0] st_wdata,
   input  logic [NREAD*DW-1:0]  rf_rdata,
   output logic [NREAD*DW-1:0]  fwd_rdata,
   output logic                 stall,
   output logic [31:0]          stall_cnt
);

   logic [NSTAGE-1:0]    tv_r;
   logic [NSTAGE-1:0]    tv_nxt_s;
   logic [NSTAGE*AW-1:0] ta_r;
   logic [NSTAGE*AW-1:0] ta_nxt_s;
   logic [NSTAGE-1:0]    src_tv_s;
   logic [NSTAGE*AW-1:0] src_ta_s;
   logic [NREAD-1:0]     hazard_s;
   logic                 stall_s;
   logic [31:0]          stall_cnt_r;

   // A stalled ID instruction must not create a tag in EXE.
   assign src_tv_s = {tv_r[NSTAGE-2:0] & ~flush[NSTAGE-2:0],
                      id_valid & id_rf_we & (id_rf_waddr != {AW{1'b0}}) & ~stall_s};
   assign src_ta_s = {ta_r[(NSTAGE-1)*AW-1:0], id_rf_waddr};

   // Tag next-state: flush beats load beats leave.
   always_comb begin
      tv_nxt_s = tv_r;
      ta_nxt_s = ta_r;
      for (int i = 0; i < NSTAGE; i++) begin
         if (flush[i]) begin
            tv_nxt_s[i] = 1'b0;
         end else if (st_ld[i]) begin
            tv_nxt_s[i]          = src_tv_s[i];
            ta_nxt_s[i*AW +: AW] = src_ta_s[i*AW +: AW];
         end else if (st_leave[i]) begin
            tv_nxt_s[i] = 1'b0;
         end else begin
            tv_nxt_s[i] = tv_r[i];
         end
      end
   end

   // Tag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         tv_r <= {NSTAGE{1'b0}};
         ta_r <= {(NSTAGE*AW){1'b0}};
      end else begin
         tv_r <= tv_nxt_s;
         ta_r <= ta_nxt_s;
      end
   end

   for (genvar p = 0; p < NREAD; p++) begin : g_port
      sb_port_sel #(
         .NSTAGE (NSTAGE),
         .AW     (AW),
         .DW     (DW)
      ) u_sel (
         .tv         (tv_r),
         .ta         (ta_r),
         .raddr      (id_raddr[p*AW +: AW]),
         .st_data_ok (st_data_ok),
         .st_wdata   (st_wdata),
         .rf_rdata   (rf_rdata[p*DW +: DW]),
         .hazard     (hazard_s[p]),
         .rdata      (fwd_rdata[p*DW +: DW])
      );
   end

   assign stall_s = id_valid & (|hazard_s);
   assign stall   = stall_s;

   // Saturating stalled-cycle counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_r <= 32'd0;
      end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
         stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed scoreboard bench for fwd_scoreboard; expectations follow SCOREBOARD_FWD_EN.
module tb_fwd_scoreboard;

   localparam int NS = 3;
   localparam int NR = 2;
   localparam int DW = 32;
   localparam int AW = 5;
`ifdef SCOREBOARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   localparam int K_STALL = 0;
   localparam int K_FWD0  = 1;
   localparam int K_FWD1  = 2;
   localparam int K_CNT   = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              id_valid;
   logic              id_rf_we;
   logic [AW-1:0]     id_rf_waddr;
   logic [NR*AW-1:0]  id_raddr;
   logic [NS-1:0]     st_ld;
   logic [NS-1:0]     st_leave;
   logic [NS-1:0]     flush;
   logic [NS-1:0]     st_data_ok;
   logic [NS*DW-1:0]  st_wdata;
   logic [NR*DW-1:0]  rf_rdata;
   logic [NR*DW-1:0]  fwd_rdata;
   logic              stall;
   logic [31:0]       stall_cnt;

   always #5 clk = ~clk;

   fwd_scoreboard #(.NSTAGE(NS), .NREAD(NR), .DW(DW), .AW(AW)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rf_we(id_rf_we),
      .id_rf_waddr(id_rf_waddr), .id_raddr(id_raddr), .st_ld(st_ld),
      .st_leave(st_leave), .flush(flush), .st_data_ok(st_data_ok),
      .st_wdata(st_wdata), .rf_rdata(rf_rdata), .fwd_rdata(fwd_rdata),
      .stall(stall), .stall_cnt(stall_cnt)
   );

   typedef struct {
      string       tag;
      int          kind;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int   compared   = 0;
   int   mismatched = 0;

   function automatic logic [31:0] sel(input logic [31:0] a, input logic [31:0] b);
      return FWD ? a : b;
   endfunction

   task automatic expect_v(input string tag, input int kind, input logic [31:0] val);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.val  = val;
      q.push_back(e);
   endtask

   task automatic check();
      exp_t        e;
      logic [31:0] obs;
      @(negedge clk);
      while (q.size() > 0) begin
         e = q.pop_front();
         case (e.kind)
            K_STALL: obs = {31'd0, stall};
            K_FWD0:  obs = fwd_rdata[31:0];
            K_FWD1:  obs = fwd_rdata[63:32];
            default: obs = stall_cnt;
         endcase
         compared++;
         assert (obs === e.val) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic issue(input logic [AW-1:0] wa, input logic [NS-1:0] ld);
      id_valid    = 1'b1;
      id_rf_we    = 1'b1;
      id_rf_waddr = wa;
      id_raddr    = {NR*AW{1'b0}};
      st_ld       = ld;
      tick();
      id_valid    = 1'b0;
      id_rf_we    = 1'b0;
      st_ld       = 3'b000;
   endtask

   task automatic move(input logic [NS-1:0] ld, input logic [NS-1:0] lv, input logic [NS-1:0] fl);
      st_ld    = ld;
      st_leave = lv;
      flush    = fl;
      tick();
      st_ld    = 3'b000;
      st_leave = 3'b000;
      flush    = 3'b000;
   endtask

   initial begin
      reset = 1'b1; id_valid = 1'b0; id_rf_we = 1'b0; id_rf_waddr = 5'd0;
      id_raddr = 10'd0; st_ld = 3'b000; st_leave = 3'b000; flush = 3'b000;
      st_data_ok = 3'b000; st_wdata = 96'd0; rf_rdata = 64'd0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state: no tags, operands come from the regfile.
      id_valid = 1'b1; id_raddr = {5'd0, 5'd4}; rf_rdata = {32'h0, 32'hAAAA_0004};
      expect_v("rst_stall", K_STALL, 32'd0);
      expect_v("rst_fwd0", K_FWD0, 32'hAAAA_0004);
      expect_v("rst_cnt", K_CNT, 32'd0);
      check();

      // 1: ALU r4 in EXE with data ready.
      do_reset();
      issue(5'd4, 3'b001);
      id_valid = 1'b1; id_raddr = {5'd0, 5'd4}; rf_rdata = {32'h0, 32'hAAAA_0004};
      st_data_ok = 3'b001; st_wdata = {64'd0, 32'h0000_1234};
      expect_v("t1_stall", K_STALL, sel(32'd0, 32'd1));
      expect_v("t1_fwd0", K_FWD0, sel(32'h0000_1234, 32'hAAAA_0004));
      expect_v("t1_fwd1_r0", K_FWD1, 32'h0);
      check();

      // 2: load r5 in EXE; stalled issue of r9 must not create a tag.
      do_reset();
      issue(5'd5, 3'b001);
      id_valid = 1'b1; id_raddr = {5'd9, 5'd5}; rf_rdata = {32'h5555_0009, 32'hAAAA_0005};
      st_data_ok = 3'b000; st_wdata = {64'd0, 32'h0000_DEAD};
      expect_v("t2_stall_exe", K_STALL, 32'd1);
      expect_v("t2_fwd0_exe", K_FWD0, sel(32'h0000_DEAD, 32'hAAAA_0005));
      check();
      id_rf_we = 1'b1; id_rf_waddr = 5'd9;
      move(3'b011, 3'b000, 3'b000);
      id_rf_we = 1'b0;
      st_data_ok = 3'b010; st_wdata = {32'd0, 32'h0000_BEEF, 32'h0000_7777};
      expect_v("t2_stall_mem", K_STALL, sel(32'd0, 32'd1));
      expect_v("t2_fwd0_mem", K_FWD0, sel(32'h0000_BEEF, 32'hAAAA_0005));
      expect_v("t2_fwd1_blocked", K_FWD1, 32'h5555_0009);
      expect_v("t2_cnt", K_CNT, 32'd1);
      check();

      // 3: r6 in all three stages, youngest wins; then only WB left.
      do_reset();
      issue(5'd6, 3'b001);
      issue(5'd6, 3'b011);
      issue(5'd6, 3'b111);
      id_valid = 1'b1; id_raddr = {5'd6, 5'd6}; rf_rdata = {32'h5555_0006, 32'hAAAA_0006};
      st_data_ok = 3'b111; st_wdata = {32'h3, 32'h2, 32'h1};
      expect_v("t3_stall", K_STALL, sel(32'd0, 32'd1));
      expect_v("t3_fwd0", K_FWD0, sel(32'h1, 32'hAAAA_0006));
      expect_v("t3_fwd1", K_FWD1, sel(32'h1, 32'h5555_0006));
      check();
      id_valid = 1'b0;
      move(3'b000, 3'b000, 3'b011);
      id_valid = 1'b1;
      expect_v("t3_wb_stall", K_STALL, sel(32'd0, 32'd1));
      expect_v("t3_wb_fwd0", K_FWD0, sel(32'h3, 32'hAAAA_0006));
      check();

      // 4: write to r0 never produces a tag; read of r0 is regfile zero.
      do_reset();
      issue(5'd0, 3'b001);
      id_valid = 1'b1; id_raddr = 10'd0; rf_rdata = 64'd0;
      st_data_ok = 3'b000; st_wdata = {64'd0, 32'h0000_9999};
      expect_v("t4_stall", K_STALL, 32'd0);
      expect_v("t4_fwd0", K_FWD0, 32'd0);
      check();

      // 5: flush[0] with st_ld[1] kills the r7 load on its way to MEM.
      do_reset();
      issue(5'd7, 3'b001);
      move(3'b010, 3'b000, 3'b001);
      id_valid = 1'b1; id_raddr = {5'd0, 5'd7}; rf_rdata = {32'h0, 32'hAAAA_0007};
      st_data_ok = 3'b000; st_wdata = {32'h0000_7003, 32'h0000_7002, 32'h0000_7001};
      expect_v("t5_stall", K_STALL, 32'd0);
      expect_v("t5_fwd0", K_FWD0, 32'hAAAA_0007);
      check();

      // 6: ALU r8 walks EXE->MEM->WB->gone, then reset mid-stall.
      do_reset();
      issue(5'd8, 3'b001);
      id_valid = 1'b1; id_raddr = {5'd0, 5'd8}; rf_rdata = {32'h0, 32'hAAAA_0008};
      st_data_ok = 3'b111; st_wdata = {32'h8080_0003, 32'h8080_0002, 32'h8080_0001};
      expect_v("t6_stall_exe", K_STALL, sel(32'd0, 32'd1));
      expect_v("t6_fwd0_exe", K_FWD0, sel(32'h8080_0001, 32'hAAAA_0008));
      check();
      move(3'b010, 3'b001, 3'b000);
      expect_v("t6_stall_mem", K_STALL, sel(32'd0, 32'd1));
      expect_v("t6_fwd0_mem", K_FWD0, sel(32'h8080_0002, 32'hAAAA_0008));
      expect_v("t6_cnt1", K_CNT, sel(32'd0, 32'd1));
      check();
      move(3'b100, 3'b010, 3'b000);
      expect_v("t6_stall_wb", K_STALL, sel(32'd0, 32'd1));
      expect_v("t6_fwd0_wb", K_FWD0, sel(32'h8080_0003, 32'hAAAA_0008));
      expect_v("t6_cnt2", K_CNT, sel(32'd0, 32'd2));
      check();
      move(3'b000, 3'b100, 3'b000);
      expect_v("t6_stall_gone", K_STALL, 32'd0);
      expect_v("t6_fwd0_gone", K_FWD0, 32'hAAAA_0008);
      expect_v("t6_cnt3", K_CNT, sel(32'd0, 32'd3));
      check();
      issue(5'd8, 3'b001);
      id_valid = 1'b1; id_raddr = {5'd0, 5'd8};
      expect_v("t6_restall", K_STALL, sel(32'd0, 32'd1));
      check();
      do_reset();
      expect_v("t6_rst_stall", K_STALL, 32'd0);
      expect_v("t6_rst_cnt", K_CNT, 32'd0);
      check();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
